// File: rtl/systolic_output_deskew_if.sv
// Bundle of the row-stream signals between the systolic array bottom edge and the deskew block.
interface systolic_output_deskew_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int SA_LENGTH     = 256,
  parameter int ROW_CNT_WIDTH = 16
);
  logic                                  In_Valid;
  logic [ROW_CNT_WIDTH-1:0]              Num_Rows;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  Inputs;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  Outputs;
  logic                                  Out_Valid;
  logic [ROW_CNT_WIDTH-1:0]              Out_Row_Idx;
  logic                                  Out_Last;
  logic                                  Busy;

  modport master (
    output In_Valid, Num_Rows, Inputs,
    input  Outputs, Out_Valid, Out_Row_Idx, Out_Last, Busy
  );

  modport slave (
    input  In_Valid, Num_Rows, Inputs,
    output Outputs, Out_Valid, Out_Row_Idx, Out_Last, Busy
  );
endinterface

// File: rtl/systolic_output_deskew.sv
// Removes the diagonal skew of the systolic array result stream so each row leaves in one cycle,
// and tracks row validity, row numbering within a tile, last-row flag and in-flight rows.
module systolic_output_deskew #(
  parameter int DATA_WIDTH    = 8,
  parameter int SA_LENGTH     = 256,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      ASYNC_RST,
  input  logic                      SYNC_RST,
  input  logic                      EN,
  systolic_output_deskew_if.slave   bus
);
  localparam int CNT_WIDTH = $clog2(SA_LENGTH) + 1;

  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] outputs_int;
  logic                                 out_valid;
  logic                                 out_last;
  logic                                 beat;
  logic [ROW_CNT_WIDTH-1:0]             row_idx_reg;
  logic [ROW_CNT_WIDTH-1:0]             row_idx_next;
  logic [CNT_WIDTH-1:0]                 inflight_reg;
  logic [CNT_WIDTH-1:0]                 inflight_next;

  // Column gi waits for the columns to its right; the last column needs no delay at all.
  for (genvar gi = 0; gi < SA_LENGTH; gi++) begin : g_col
    localparam int DEPTH = SA_LENGTH - 1 - gi;
    if (DEPTH == 0) begin : g_pass
      assign outputs_int[gi] = bus.Inputs[gi];
    end else begin : g_line
      logic [DATA_WIDTH-1:0] line_reg [DEPTH];
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int i = 0; i < DEPTH; i++) line_reg[i] <= '0;
        end else if (SYNC_RST) begin
          for (int i = 0; i < DEPTH; i++) line_reg[i] <= '0;
        end else if (EN) begin
          line_reg[0] <= bus.Inputs[gi];
          for (int i = 1; i < DEPTH; i++) line_reg[i] <= line_reg[i-1];
        end
      end
      assign outputs_int[gi] = line_reg[DEPTH-1];
    end
  end

  if (SA_LENGTH == 1) begin : g_vpass
    assign out_valid = bus.In_Valid;
  end else begin : g_vpipe
    logic [SA_LENGTH-2:0] vpipe_reg;
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        vpipe_reg <= '0;
      end else if (SYNC_RST) begin
        vpipe_reg <= '0;
      end else if (EN) begin
        vpipe_reg[0] <= bus.In_Valid;
        for (int i = 1; i < SA_LENGTH - 1; i++) vpipe_reg[i] <= vpipe_reg[i-1];
      end
    end
    assign out_valid = vpipe_reg[SA_LENGTH-2];
  end

  assign beat     = EN & out_valid;
  // A zero row count means "no tile boundary": the index simply rolls over.
  assign out_last = out_valid && (bus.Num_Rows != '0) &&
                    (row_idx_reg == bus.Num_Rows - ROW_CNT_WIDTH'(1));

  always_comb begin
    row_idx_next = row_idx_reg;
    if (beat) begin
      row_idx_next = out_last ? '0 : row_idx_reg + ROW_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    inflight_next = inflight_reg;
    case ({EN & bus.In_Valid, beat})
      2'b10:   inflight_next = inflight_reg + CNT_WIDTH'(1);
      2'b01:   inflight_next = inflight_reg - CNT_WIDTH'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      row_idx_reg  <= '0;
      inflight_reg <= '0;
    end else if (SYNC_RST) begin
      row_idx_reg  <= '0;
      inflight_reg <= '0;
    end else begin
      row_idx_reg  <= row_idx_next;
      inflight_reg <= inflight_next;
    end
  end

  assign bus.Outputs     = outputs_int;
  assign bus.Out_Valid   = out_valid;
  assign bus.Out_Row_Idx = row_idx_reg;
  assign bus.Out_Last    = out_last;
  assign bus.Busy        = (inflight_reg != '0);
endmodule
